// File: rtl/mac_rx_rmii_front.sv
// RMII receive front end: registers CRS_DV/RXD, strips preamble/SFD and streams
// payload dibits into the rx dibit FIFO while tracking frame length and errors.
module mac_rx_rmii_front #(
  parameter int MIN_PRE_DIBITS = 8,
  parameter int MIN_DIBITS     = 256,
  parameter int MAX_DIBITS     = 6072,
  parameter int CNT_W          = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I_crs_dv,
  input  logic [1:0]       I_rxd,
  input  logic             I_fifo_full,
  output logic             O_fifo_wr,
  output logic [1:0]       O_fifo_data,
  output logic             O_frame_start,
  output logic             O_frame_end,
  output logic             O_frame_err,
  output logic [CNT_W-1:0] O_dibit_cnt,
  output logic             O_busy
);

  localparam int PRE_W = $clog2(MIN_PRE_DIBITS + 1);
  localparam logic [PRE_W-1:0] PRE_MIN = PRE_W'(MIN_PRE_DIBITS);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_DIBITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIBITS);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t           state, state_next;
  logic             crs_q;
  logic [1:0]       rxd_q;
  logic [PRE_W-1:0] pre_cnt, pre_cnt_next;
  logic [CNT_W-1:0] dibit_cnt, dibit_cnt_next;
  logic             bad_drop, bad_drop_next;
  logic             wr_next, start_next, end_next, err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crs_q         <= 1'b0;
      rxd_q         <= 2'b00;
      state         <= IDLE;
      pre_cnt       <= '0;
      dibit_cnt     <= '0;
      bad_drop      <= 1'b0;
      O_fifo_wr     <= 1'b0;
      O_fifo_data   <= 2'b00;
      O_frame_start <= 1'b0;
      O_frame_end   <= 1'b0;
      O_frame_err   <= 1'b0;
    end else begin
      crs_q         <= I_crs_dv;
      rxd_q         <= I_rxd;
      state         <= state_next;
      pre_cnt       <= pre_cnt_next;
      dibit_cnt     <= dibit_cnt_next;
      bad_drop      <= bad_drop_next;
      O_fifo_wr     <= wr_next;
      O_fifo_data   <= rxd_q;
      O_frame_start <= start_next;
      O_frame_end   <= end_next;
      O_frame_err   <= err_next;
    end
  end

  assign O_dibit_cnt = dibit_cnt;
  assign O_busy      = (state != IDLE);

  always_comb begin
    state_next     = state;
    pre_cnt_next   = pre_cnt;
    dibit_cnt_next = dibit_cnt;
    bad_drop_next  = bad_drop;
    wr_next        = 1'b0;
    start_next     = 1'b0;
    end_next       = 1'b0;
    err_next       = 1'b0;
    case (state)
      IDLE: begin
        if (crs_q) begin
          if (rxd_q == 2'b01) begin
            state_next   = PRE;
            pre_cnt_next = PRE_W'(1);
          end else begin
            state_next    = DROP;
            bad_drop_next = 1'b0;
          end
        end
      end
      PRE: begin
        if (!crs_q) begin
          state_next = IDLE;
        end else if (rxd_q == 2'b01) begin
          if (pre_cnt < PRE_MIN) pre_cnt_next = pre_cnt + 1'b1;
        end else if (rxd_q == 2'b11 && pre_cnt >= PRE_MIN) begin
          state_next     = DATA;
          dibit_cnt_next = '0;
        end else begin
          state_next    = DROP;
          bad_drop_next = 1'b0;
        end
      end
      DATA: begin
        if (!crs_q) begin
          state_next = IDLE;
          end_next   = 1'b1;
          err_next   = (dibit_cnt < CNT_MIN) || (dibit_cnt[1:0] != 2'b00);
        end else if (I_fifo_full || dibit_cnt == CNT_MAX) begin
          // Overflow or over-length: abandon, report once carrier drops.
          state_next    = DROP;
          bad_drop_next = 1'b1;
        end else begin
          wr_next        = 1'b1;
          start_next     = (dibit_cnt == '0);
          dibit_cnt_next = dibit_cnt + 1'b1;
        end
      end
      DROP: begin
        if (!crs_q) begin
          state_next    = IDLE;
          end_next      = bad_drop;
          err_next      = bad_drop;
          bad_drop_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_rx_rmii_front.sv
// Randomized scoreboard bench for mac_rx_rmii_front: a frame-level model predicts
// every FIFO write and frame-end report; a negedge monitor checks them as they appear.
module tb_mac_rx_rmii_front;

  localparam int MIN_PRE = 8;
  localparam int MIN_D   = 256;
  localparam int MAX_D   = 6072;
  localparam int CNT_W   = 13;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             crs_dv = 1'b0;
  logic [1:0]       rxd = 2'b00;
  logic             fifo_full = 1'b0;
  logic             fifo_wr;
  logic [1:0]       fifo_data;
  logic             frame_start, frame_end, frame_err, busy;
  logic [CNT_W-1:0] dibit_cnt;

  mac_rx_rmii_front #(
    .MIN_PRE_DIBITS(MIN_PRE), .MIN_DIBITS(MIN_D), .MAX_DIBITS(MAX_D), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .I_crs_dv(crs_dv), .I_rxd(rxd), .I_fifo_full(fifo_full),
    .O_fifo_wr(fifo_wr), .O_fifo_data(fifo_data), .O_frame_start(frame_start),
    .O_frame_end(frame_end), .O_frame_err(frame_err), .O_dibit_cnt(dibit_cnt),
    .O_busy(busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [1:0] d; int cyc; bit first;} wr_t;
  typedef struct {bit err; int cnt; int cyc;} end_t;
  wr_t wq[$];
  end_t eq[$];
  wr_t w;
  end_t e;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consumes expectations as the DUT presents writes / frame ends.
  always @(negedge clk) begin
    if (!rst) begin
      if (wq.size() > 0 && wq[0].cyc < cyc) begin
        chk("missing_write", cyc, wq[0].cyc);
        void'(wq.pop_front());
      end
      if (eq.size() > 0 && eq[0].cyc < cyc) begin
        chk("missing_frame_end", cyc, eq[0].cyc);
        void'(eq.pop_front());
      end
      if (fifo_wr) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          w = wq.pop_front();
          chk("wr_data", int'(fifo_data), int'(w.d));
          chk("wr_cycle", cyc, w.cyc);
          chk("frame_start", int'(frame_start), int'(w.first));
          chk("busy_on_write", int'(busy), 1);
          $display("write d=%0d cyc=%0d start=%0d", fifo_data, cyc, frame_start);
        end
      end else if (frame_start) chk("stray_start", 1, 0);
      if (frame_end) begin
        if (eq.size() == 0) chk("unexpected_frame_end", 1, 0);
        else begin
          e = eq.pop_front();
          chk("end_err", int'(frame_err), int'(e.err));
          chk("end_cnt", int'(dibit_cnt), e.cnt);
          chk("end_cycle", cyc, e.cyc);
          $display("frame_end err=%0d cnt=%0d cyc=%0d", frame_err, dibit_cnt, cyc);
        end
      end else if (frame_err) chk("stray_err", 1, 0);
    end
  end

  task automatic slot(input logic c, input logic [1:0] d, input logic f);
    @(posedge clk);
    #1;
    crs_dv = c;
    rxd = d;
    fifo_full = f;
  endtask

  function automatic int all_outputs();
    return int'({fifo_wr, fifo_data, frame_start, frame_end, frame_err, dibit_cnt, busy});
  endfunction

  // full_at: FIFO reports full once full_at dibits are written (-1 = never).
  // rst_at: payload index at which reset is pulsed instead (-1 = never).
  task automatic send_frame(input int pre_len, input logic [1:0] sfd, input int len,
                            input int full_at, input int gap, input int rst_at);
    logic [1:0] pay[$];
    int ps, nw;
    bit bad;
    for (int i = 0; i < len; i++) pay.push_back(2'($urandom));
    ps = cyc + 1 + pre_len + 1;
    if (pre_len >= MIN_PRE && sfd == 2'b11) begin
      nw = len;
      bad = 1'b0;
      if (full_at >= 0 && full_at < nw) begin nw = full_at; bad = 1'b1; end
      if (nw > MAX_D) begin nw = MAX_D; bad = 1'b1; end
      for (int i = 0; i < nw; i++)
        if (rst_at < 0 || i < rst_at - 2) wq.push_back('{pay[i], ps + i + 2, (i == 0)});
      if (rst_at < 0)
        eq.push_back('{(bad || nw < MIN_D || (nw % 4) != 0), nw, ps + len + 2});
    end
    for (int i = 0; i < pre_len; i++) slot(1'b1, 2'b01, 1'b0);
    slot(1'b1, sfd, 1'b0);
    for (int j = 0; j < len; j++) begin
      if (j == rst_at) begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        crs_dv = 1'b0;
        fifo_full = 1'b0;
        @(negedge clk);
        chk("reset_mid_frame", all_outputs(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      slot(1'b1, pay[j], (full_at >= 0 && j > full_at));
    end
    for (int g = 0; g < gap; g++)
      slot(1'b0, 2'($urandom), (full_at >= 0 && (len + g) > full_at));
    if (gap >= 3) begin
      @(negedge clk);
      chk("busy_idle", int'(busy), 0);
    end
  endtask

  initial begin
    int pl, ln, fa, gp;
    logic [1:0] sf;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outputs(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send_frame(28, 2'b11, 256, -1, 4, -1);   // good minimum frame
    send_frame(4, 2'b11, 40, -1, 4, -1);     // preamble too short
    send_frame(8, 2'b11, 100, -1, 3, -1);    // short
    send_frame(10, 2'b11, 257, -1, 3, -1);   // misaligned
    send_frame(12, 2'b11, 300, 50, 3, -1);   // overflow after 50 writes
    send_frame(9, 2'b11, 6100, -1, 3, -1);   // too long
    send_frame(16, 2'b11, 300, -1, 3, 120);  // reset mid-DATA
    send_frame(16, 2'b11, 260, -1, 1, -1);   // one-cycle gap
    send_frame(8, 2'b11, 256, -1, 3, -1);
    send_frame(12, 2'b10, 64, -1, 3, -1);    // bad SFD
    send_frame(0, 2'b00, 64, -1, 3, -1);     // no preamble

    for (int k = 0; k < 30; k++) begin
      pl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(8, 24));
      sf = ($urandom_range(0, 4) != 0) ? 2'b11 : (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00);
      ln = ($urandom_range(0, 1) != 0) ? int'(4 * $urandom_range(64, 170)) : int'($urandom_range(1, 700));
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ln)) : -1;
      gp = int'($urandom_range(1, 5));
      send_frame(pl, sf, ln, fa, gp, -1);
    end

    repeat (10) slot(1'b0, 2'b00, 1'b0);
    @(negedge clk);
    chk("queues_drained", wq.size() + eq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: time limit reached, pending writes=%0d ends=%0d", wq.size(), eq.size());
    $fatal(1, "watchdog expired");
  end

endmodule
